// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered LSU writebacks onto the single regfile write port
module regfile_wb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_rd_i,
  input  logic [31:0]              alu_wdata_i,
  output logic                     alu_stall_o,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [4:0]               lsu_rd_i,
  input  logic [31:0]              lsu_wdata_i,
  output logic [4:0]               rd_o,
  output logic                     we_o,
  output logic [31:0]              wdata_o,
  output logic [31:0]              pending_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     proto_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starv_q, starv_d;
  logic          alu_stall_q, alu_stall_d;
  logic          lsu_ready_q, lsu_ready_d;
  logic          we_q, we_d;
  logic          proto_err_q, proto_err_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          alu_win, alu_write, pop, push;
  logic [31:0]   pending_d;

  // Arbitration: an unstalled ALU result wins, otherwise the FIFO head drains
  always_comb begin
    alu_win     = alu_valid_i && !alu_stall_q;
    alu_write   = alu_win && (alu_rd_i != 5'd0);
    pop         = !alu_win && (count_q != '0);
    push        = lsu_valid_i && lsu_ready_q && (lsu_rd_i != 5'd0);
    count_d     = count_q + CW'(push) - CW'(pop);
    lsu_ready_d = count_d < FULL;
    starv_d     = (pop || count_q == '0) ? '0 : alu_win ? starv_q + SW'(1) : starv_q;
    alu_stall_d = starv_d == SMAX;
    we_d        = alu_write || pop;
    rd_d        = alu_write ? alu_rd_i : pop ? mem_rd_q[rd_ptr_q] : 5'd0;
    wdata_d     = alu_write ? alu_wdata_i : pop ? mem_data_q[rd_ptr_q] : 32'd0;
    proto_err_d = proto_err_q || (alu_valid_i && alu_stall_q);
  end

  // Pending map: every live FIFO entry marks its destination register
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i]) pending_d[mem_rd_q[i]] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State update, FIFO storage and registered write port
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starv_q     <= '0;
      alu_stall_q <= 1'b0;
      lsu_ready_q <= 1'b1;
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      wdata_q     <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      starv_q     <= starv_d;
      alu_stall_q <= alu_stall_d;
      lsu_ready_q <= lsu_ready_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
      if (push) begin
        mem_rd_q[wr_ptr_q]   <= lsu_rd_i;
        mem_data_q[wr_ptr_q] <= lsu_wdata_i;
        valid_q[wr_ptr_q]    <= 1'b1;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign alu_stall_o = alu_stall_q;
  assign lsu_ready_o = lsu_ready_q;
  assign rd_o        = rd_q;
  assign we_o        = we_q;
  assign wdata_o     = wdata_q;
  assign pending_o   = pending_d;
  assign count_o     = count_q;
  assign proto_err_o = proto_err_q;
endmodule
